// File: rtl/mem_responder.sv
// mem_responder: single-port 256x16 memory behind a request/done handshake.
// Each accepted request spends WAIT_CYCLES+1 cycles in ACCESS (waiting=1),
// then one cycle in DONE (done=1), then returns to IDLE. The array itself is
// never reset; only the control state and the read-data register are.
module mem_responder #(
  parameter int unsigned WAIT_CYCLES = 1  // extra wait states, 0..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [15:0] w_data,
  output logic [15:0] r_data,
  output logic        waiting,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        we_reg;
  logic [7:0]  addr_reg;
  logic [15:0] wdata_reg;
  logic        waiting_next, done_next;
  logic        access_fire;

  logic [15:0] mem [256];

  // The access happens on the edge that leaves ACCESS for DONE.
  assign access_fire = (state_reg == ACCESS) && (cnt_reg == 4'd0);

  // State and wait counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next = ACCESS;
          cnt_next   = WAIT_LOAD;
        end
      end
      ACCESS: begin
        if (cnt_reg == 4'd0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DONE: begin
        // Never accept here, even with req held high; IDLE takes it next.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Output decode from the next state so the flops below line up with state_reg
  always_comb begin
    waiting_next = (state_next == ACCESS);
    done_next    = (state_next == DONE);
  end

  // Registered outputs; r_data only moves on a completing read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waiting <= 1'b0;
      done    <= 1'b0;
      r_data  <= 16'h0000;
    end else begin
      waiting <= waiting_next;
      done    <= done_next;
      if (access_fire && !we_reg) begin
        r_data <= mem[addr_reg];
      end
    end
  end

  // Request capture: only sampled while idle, later input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg    <= 1'b0;
      addr_reg  <= 8'h00;
      wdata_reg <= 16'h0000;
    end else if (state_reg == IDLE && req) begin
      we_reg    <= we;
      addr_reg  <= addr;
      wdata_reg <= w_data;
    end
  end

  // Array write port; no reset so contents survive rst_n. An aborted access
  // never reaches access_fire because reset forces the state back to IDLE.
  always_ff @(posedge clk) begin
    if (access_fire && we_reg) begin
      mem[addr_reg] <= wdata_reg;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: three instances (WAIT_CYCLES 0, 1, 3) share one
// stimulus stream; a queue holds the expected r_data for each issued access.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [15:0] w_data = 16'h0000;

  logic [15:0] rd [3];
  logic        wt [3];
  logic        dn [3];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } sb_t;

  sb_t         sb [$];
  logic [15:0] model [256];
  logic [15:0] exp_rdata = 16'h0000;

  // index 0: WAIT_CYCLES=0, 1: WAIT_CYCLES=1, 2: WAIT_CYCLES=3
  int exp_first [3] = '{2, 3, 5};
  int exp_wait  [3] = '{1, 2, 4};
  int wait_val  [3] = '{0, 1, 3};

  always #5 clk = ~clk;

  mem_responder #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .w_data(w_data),
    .r_data(rd[0]), .waiting(wt[0]), .done(dn[0])
  );
  mem_responder #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .w_data(w_data),
    .r_data(rd[1]), .waiting(wt[1]), .done(dn[1])
  );
  mem_responder #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .w_data(w_data),
    .r_data(rd[2]), .waiting(wt[2]), .done(dn[2])
  );

  // Drive a request and record what the scoreboard should see on completion.
  task automatic issue(input logic w, input logic [7:0] a, input logic [15:0] d);
    sb_t e;
    req = 1'b1; we = w; addr = a; w_data = d;
    if (w) model[a] = d;
    else   exp_rdata = model[a];
    e.addr = a;
    e.data = exp_rdata;
    sb.push_back(e);
  endtask

  // Let the request be sampled, then watch all instances for 8 cycles.
  task automatic observe(input bit scramble, input bit is_write);
    int  first [3];
    int  ndone [3];
    int  nwait [3];
    sb_t e;
    @(posedge clk); #1;
    req = 1'b0;
    if (scramble) begin
      we = ~we; addr = addr + 8'd1; w_data = ~w_data;
    end
    for (int i = 0; i < 3; i++) begin
      first[i] = -1; ndone[i] = 0; nwait[i] = 0;
    end
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (dn[i] === 1'b1) begin
          ndone[i]++;
          if (first[i] < 0) first[i] = n;
        end
        if (wt[i] === 1'b1) nwait[i]++;
        if (is_write) begin
          checks++;
          if (rd[i] !== exp_rdata) begin
            errors++;
            $display("FAIL r_data_hold_during_write W=%0d cycle %0d: got %h expected %h",
                     wait_val[i], n, rd[i], exp_rdata);
          end
        end
      end
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (first[i] != exp_first[i]) begin
        errors++;
        $display("FAIL done_latency W=%0d addr %h: got cycle %0d expected %0d",
                 wait_val[i], e.addr, first[i], exp_first[i]);
      end
      checks++;
      if (ndone[i] != 1) begin
        errors++;
        $display("FAIL done_width W=%0d addr %h: got %0d cycles expected 1",
                 wait_val[i], e.addr, ndone[i]);
      end
      checks++;
      if (nwait[i] != exp_wait[i]) begin
        errors++;
        $display("FAIL waiting_width W=%0d addr %h: got %0d cycles expected %0d",
                 wait_val[i], e.addr, nwait[i], exp_wait[i]);
      end
      checks++;
      if (rd[i] !== e.data) begin
        errors++;
        $display("FAIL r_data W=%0d addr %h: got %h expected %h",
                 wait_val[i], e.addr, rd[i], e.data);
      end
    end
    $display("access %s addr=%h wdata=%h r_data=%h exp=%h done_at=%0d",
             is_write ? "WR" : "RD", e.addr, w_data, rd[1], e.data, first[1]);
  endtask

  task automatic run_access(input logic w, input logic [7:0] a, input logic [15:0] d,
                            input bit scramble);
    @(negedge clk);
    issue(w, a, d);
    observe(scramble, w);
  endtask

  // Reset holds everything idle even with req high; first edge after release accepts.
  task automatic test_reset();
    rst_n = 1'b0;
    req = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wt[i] !== 1'b0 || dn[i] !== 1'b0 || rd[i] !== 16'h0000) begin
          errors++;
          $display("FAIL reset_state W=%0d: got waiting=%b done=%b r_data=%h expected 0 0 0000",
                   wait_val[i], wt[i], dn[i], rd[i]);
        end
      end
    end
    $display("reset held 3 cycles with req=1");
    rst_n = 1'b1;
    issue(1'b1, 8'h10, 16'hBEEF);
    observe(1'b0, 1'b1);
  endtask

  task automatic test_write_read();
    run_access(1'b0, 8'h10, 16'h0000, 1'b0);
  endtask

  // A write must not disturb r_data from the previous read.
  task automatic test_read_hold();
    run_access(1'b0, 8'h10, 16'h0000, 1'b0);
    run_access(1'b1, 8'h11, 16'h1234, 1'b0);
    run_access(1'b0, 8'h11, 16'h0000, 1'b0);
  endtask

  // Inputs changed mid-access must be ignored: only 8'h20 is written.
  task automatic test_ignore_changes();
    run_access(1'b1, 8'h21, 16'h5555, 1'b0);
    run_access(1'b1, 8'h20, 16'hAAAA, 1'b1);
    run_access(1'b0, 8'h21, 16'h0000, 1'b0);
    run_access(1'b0, 8'h20, 16'h0000, 1'b0);
  endtask

  // Reset in the middle of a write aborts it without a clock edge.
  task automatic test_reset_abort();
    run_access(1'b1, 8'h30, 16'h0001, 1'b0);
    run_access(1'b0, 8'h10, 16'h0000, 1'b0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 8'h30; w_data = 16'hFFFF;
    @(posedge clk); #1;
    req = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wt[i] !== 1'b1) begin
        errors++;
        $display("FAIL abort_in_access W=%0d: got waiting=%b expected 1", wait_val[i], wt[i]);
      end
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wt[i] !== 1'b0 || dn[i] !== 1'b0 || rd[i] !== 16'h0000) begin
        errors++;
        $display("FAIL async_reset W=%0d: got waiting=%b done=%b r_data=%h expected 0 0 0000",
                 wait_val[i], wt[i], dn[i], rd[i]);
      end
    end
    $display("reset asserted mid-write addr=30");
    exp_rdata = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_access(1'b0, 8'h30, 16'h0000, 1'b0);
  endtask

  // req held high: three reads, done pulses 4 cycles apart on the WAIT=1 instance.
  task automatic test_back_to_back();
    logic [7:0] addrs [3];
    int         idx [3];
    int         got;
    bit         prev_done;
    sb_t        e;
    addrs = '{8'h00, 8'h01, 8'h02};
    idx = '{0, 0, 0};
    got = 0;
    prev_done = 1'b0;
    run_access(1'b1, 8'h00, 16'h1111, 1'b0);
    run_access(1'b1, 8'h01, 16'h2222, 1'b0);
    run_access(1'b1, 8'h02, 16'h3333, 1'b0);
    sb.delete();
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = addrs[0]; w_data = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      e.addr = addrs[k];
      e.data = model[addrs[k]];
      sb.push_back(e);
    end
    for (int n = 1; n <= 40 && got < 3; n++) begin
      @(negedge clk);
      if (prev_done) begin
        checks++;
        if (wt[1] !== 1'b0 || dn[1] !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle_gap cycle %0d: got waiting=%b done=%b expected 0 0",
                   n, wt[1], dn[1]);
        end
      end
      prev_done = (dn[1] === 1'b1);
      if (dn[1] === 1'b1) begin
        idx[got] = n;
        e = sb.pop_front();
        checks++;
        if (rd[1] !== e.data) begin
          errors++;
          $display("FAIL b2b_r_data addr %h: got %h expected %h", e.addr, rd[1], e.data);
        end
        $display("b2b read addr=%h r_data=%h exp=%h done_at=%0d", e.addr, rd[1], e.data, n);
        got++;
        if (got < 3) addr = addrs[got];
        else         req = 1'b0;
      end
    end
    req = 1'b0;
    checks++;
    if (got != 3) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d expected 3", got);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (idx[k] != 3 + 4 * k) begin
        errors++;
        $display("FAIL b2b_done_spacing pulse %0d: got cycle %0d expected %0d", k, idx[k], 3 + 4 * k);
      end
    end
    exp_rdata = model[8'h02];
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_hold();
    test_ignore_changes();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, meaning extra wait states per access; legal range 0..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  1  access request from CPU controller; sampled only in IDLE.
REQ-005 SHALL have port we  input  1  1 = write, 0 = read; sampled with req.
REQ-006 SHALL have port addr  input  8  word address, sampled with req.
REQ-007 SHALL have port w_data  input  16  write data, sampled with req.
REQ-008 SHALL have port r_data  output  16  read data, registered.
REQ-009 SHALL have port waiting  output  1  high while an access is in progress (drives controller waiting input).
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-011 SHALL contain a 256 x 16-bit storage array, full 8-bit address range, no out-of-range case.
REQ-012 SHALL implement FSM states IDLE, ACCESS, DONE; state, counter and all outputs registered.
REQ-013 IDLE: req=1 at edge k SHALL latch addr/we/w_data, load 4-bit counter with WAIT_CYCLES, go to ACCESS; req=0 stays IDLE.
REQ-014 ACCESS: counter non-zero SHALL decrement and remain; counter zero SHALL perform the access and go to DONE at that edge.
REQ-015 Access at ACCESS->DONE edge: write SHALL update array[latched addr] with latched w_data; read SHALL load r_data with array[latched addr].
REQ-016 DONE SHALL last exactly one cycle then go to IDLE unconditionally.
REQ-017 Latency: req sampled at edge k SHALL give done=1 in the cycle after edge k+WAIT_CYCLES+1 (WAIT_CYCLES=0 -> 2 edges, never same-cycle).
REQ-018 waiting SHALL be 1 exactly in ACCESS, 0 in IDLE and DONE.
REQ-019 done SHALL be 1 exactly in DONE, for one cycle per accepted request.
REQ-020 r_data SHALL hold its value until the next completing read; writes SHALL NOT change r_data.
REQ-021 Changes on req/we/addr/w_data during ACCESS or DONE SHALL be ignored; req high in DONE SHALL NOT be accepted; accepted only on return to IDLE.
REQ-022 Back-to-back: req held high continuously SHALL start a new access at the first IDLE edge after DONE (one idle cycle between done and next waiting).
REQ-023 Write then read of the same address SHALL return the written value (no stale data).

Reset
REQ-024 rst_n=0 SHALL immediately, independent of clk, force state IDLE, counter 0, waiting 0, done 0, r_data 16'h0000.
REQ-025 Reset during ACCESS SHALL abort the access: pending write SHALL NOT modify the array.
REQ-026 Array contents SHALL NOT be cleared by reset; content after power-up undefined until written.
REQ-027 First request SHALL be accepted at the first rising edge after rst_n deasserts with req=1.

Verification
REQ-028 WAIT_CYCLES=1: write addr 8'h10 data 16'hBEEF, then read 8'h10 -> r_data=16'hBEEF on done; waiting high exactly 2 cycles per access.
REQ-029 WAIT_CYCLES=0 and =3: req at edge k -> done high after edge k+1 and k+4 respectively, one cycle wide.
REQ-030 Read 8'h10 (16'hBEEF) then write 8'h11 16'h1234 -> r_data remains 16'hBEEF through and after the write.
REQ-031 Change addr/w_data/we mid-ACCESS (8'h20->8'h21) -> only latched address 8'h20 accessed; 8'h21 unchanged.
REQ-032 Assert rst_n=0 mid-write to 8'h30 (previously 16'h0001) -> waiting/done/r_data 0 without clock edge; later read of 8'h30 returns 16'h0001.
REQ-033 req held high for 3 reads of 8'h00,8'h01,8'h02 -> three done pulses, each separated by one IDLE cycle, correct data each.
